// File: rtl/multi_pulse_generator_if.sv
// Control and output bundle for the multi-channel pulse/PWM generator.
// Channel c occupies [c*N +: N] of period/width and [c*M +: M] of burst.
interface multi_pulse_generator_if #(
    parameter int unsigned C = 4,
    parameter int unsigned N = 8,
    parameter int unsigned M = 8
);
    logic [C-1:0]   ena;
    logic [C-1:0]   start;
    logic [C-1:0]   mode;
    logic           sync;
    logic [C*N-1:0] period;
    logic [C*N-1:0] width;
    logic [C*M-1:0] burst;
    logic [C-1:0]   out;
    logic [C-1:0]   busy;
    logic [C-1:0]   done;

    modport master (
        output ena, start, mode, sync, period, width, burst,
        input  out, busy, done
    );

    modport slave (
        input  ena, start, mode, sync, period, width, burst,
        output out, busy, done
    );
endinterface

// File: rtl/multi_pulse_generator.sv
// C independent pulse/PWM channels, each continuous or triggered-burst, with a global
// sync strobe that restarts the period of every running channel.
module multi_pulse_generator #(
    parameter int unsigned C = 4,
    parameter int unsigned N = 8,
    parameter int unsigned M = 8
) (
    input logic                      clk,
    input logic                      rst,
    multi_pulse_generator_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    logic [C-1:0] out_w;
    logic [C-1:0] busy_w;
    logic [C-1:0] done_w;

    for (genvar c = 0; c < C; c++) begin : g_ch
        state_e         state_q, state_d;
        logic [N-1:0]   cnt_q, cnt_d;
        logic [N-1:0]   p_q, p_d;
        logic [N-1:0]   w_q, w_d;
        logic [M-1:0]   rem_q, rem_d;
        logic           burst_q, burst_d;
        logic           done_q, done_d;
        logic [N-1:0]   period_c;
        logic [N-1:0]   width_c;
        logic [M-1:0]   burst_c;
        logic           wrap;

        assign period_c = bus.period[c*N +: N];
        assign width_c  = bus.width[c*N +: N];
        assign burst_c  = bus.burst[c*M +: M];
        // cnt never exceeds p_q-1, so the increment below cannot overflow.
        assign wrap     = (cnt_q == p_q - N'(1));

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            p_d     = p_q;
            w_d     = w_q;
            rem_d   = rem_q;
            burst_d = burst_q;
            done_d  = 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.mode[c]) begin
                        if (bus.start[c]) begin
                            if (period_c == '0 || burst_c == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = StRun;
                                cnt_d   = '0;
                                p_d     = period_c;
                                w_d     = width_c;
                                rem_d   = burst_c;
                                burst_d = 1'b1;
                            end
                        end
                    end else if (bus.ena[c] && period_c != '0) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        p_d     = period_c;
                        w_d     = width_c;
                        burst_d = 1'b0;
                    end
                end
                StRun: begin
                    if (!burst_q && !bus.ena[c]) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (bus.sync || wrap) begin
                        // A sync on the same edge as the final wrap keeps the burst alive.
                        if (!bus.sync && burst_q && rem_q == M'(1)) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = '0;
                            p_d   = period_c;
                            w_d   = width_c;
                            if (!bus.sync && burst_q) begin
                                rem_d = rem_q - M'(1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + N'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                p_q     <= '0;
                w_q     <= '0;
                rem_q   <= '0;
                burst_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                p_q     <= p_d;
                w_q     <= w_d;
                rem_q   <= rem_d;
                burst_q <= burst_d;
                done_q  <= done_d;
            end
        end

        assign out_w[c]  = (state_q == StRun) && (cnt_q < w_q);
        assign busy_w[c] = (state_q == StRun);
        assign done_w[c] = done_q;
    end

    assign bus.out  = out_w;
    assign bus.busy = busy_w;
    assign bus.done = done_w;

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Table-driven bench for multi_pulse_generator: each vector is applied for one cycle and
// the outputs visible after the following rising edge are checked from a scoreboard queue.
module tb_multi_pulse_generator;
    localparam int unsigned C = 4;
    localparam int unsigned N = 8;
    localparam int unsigned M = 8;

    typedef struct {
        logic [C-1:0]   ena;
        logic [C-1:0]   start;
        logic [C-1:0]   mode;
        logic           sync;
        logic [C*N-1:0] period;
        logic [C*N-1:0] width;
        logic [C*M-1:0] burst;
        logic [C-1:0]   eo;
        logic [C-1:0]   eb;
        logic [C-1:0]   ed;
    } vec_t;

    typedef struct {
        logic [C-1:0] eo;
        logic [C-1:0] eb;
        logic [C-1:0] ed;
        int           idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_pulse_generator_if #(.C(C), .N(N), .M(M)) bus ();

    multi_pulse_generator #(.C(C), .N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t         vecs[$];
    exp_t         sb[$];
    logic [N-1:0] cp[C];
    logic [N-1:0] cw[C];
    logic [M-1:0] cb[C];
    int           errors = 0;
    int           checks = 0;

    function automatic vec_t mk(input logic [C-1:0] ena, input logic [C-1:0] st,
                                input logic [C-1:0] md, input logic sy,
                                input logic [C-1:0] eo, input logic [C-1:0] eb,
                                input logic [C-1:0] ed);
        vec_t v;
        v.ena = ena; v.start = st; v.mode = md; v.sync = sy;
        v.eo = eo; v.eb = eb; v.ed = ed;
        for (int c = 0; c < C; c++) begin
            v.period[c*N +: N] = cp[c];
            v.width[c*N +: N]  = cw[c];
            v.burst[c*M +: M]  = cb[c];
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [C-1:0] act, input logic [C-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        bus.ena = v.ena; bus.start = v.start; bus.mode = v.mode; bus.sync = v.sync;
        bus.period = v.period; bus.width = v.width; bus.burst = v.burst;
        e.eo = v.eo; e.eb = v.eb; e.ed = v.ed; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d out", e.idx), bus.out, e.eo);
        check($sformatf("v%0d busy", e.idx), bus.busy, e.eb);
        check($sformatf("v%0d done", e.idx), bus.done, e.ed);
    endtask

    initial begin
        logic [C-1:0] en, st, eo, eb, ed;
        int c0, c1, c3, r;

        for (int c = 0; c < C; c++) begin
            cp[c] = '0; cw[c] = '0; cb[c] = '0;
        end

        // Continuous ch0, P=5 W=2, then ena dropped.
        cp[0] = 8'd5; cw[0] = 8'd2;
        for (int k = 0; k < 10; k++) begin
            en = '0; eo = '0; eb = '0;
            en[0] = (k < 8);
            eo[0] = (k < 8) && (k % 5 < 2);
            eb[0] = (k < 8);
            vecs.push_back(mk(en, 4'b0000, 4'b0000, 1'b0, eo, eb, 4'b0000));
        end

        // Burst ch1, P=4 W=1 burst=3; second start while running is ignored.
        cp[1] = 8'd4; cw[1] = 8'd1; cb[1] = 8'd3;
        for (int k = 0; k < 14; k++) begin
            st = '0; eo = '0; eb = '0; ed = '0;
            st[1] = (k == 0) || (k == 3);
            eo[1] = (k < 12) && (k % 4 == 0);
            eb[1] = (k < 12);
            ed[1] = (k == 12);
            vecs.push_back(mk(4'b0000, st, 4'b0010, 1'b0, eo, eb, ed));
        end

        // ch2, W=0 burst of 2 at P=3: no output but done still arrives.
        cp[2] = 8'd3; cw[2] = 8'd0; cb[2] = 8'd2;
        for (int k = 0; k < 8; k++) begin
            st = '0; eb = '0; ed = '0;
            st[2] = (k == 0);
            eb[2] = (k < 6);
            ed[2] = (k == 6);
            vecs.push_back(mk(4'b0000, st, 4'b0100, 1'b0, 4'b0000, eb, ed));
        end

        // ch2, W=6 >= P=4 continuous: out constant 1.
        cp[2] = 8'd4; cw[2] = 8'd6; cb[2] = 8'd0;
        for (int k = 0; k < 7; k++) begin
            en = '0; eo = '0; eb = '0;
            en[2] = (k < 6);
            eo[2] = (k < 6);
            eb[2] = (k < 6);
            vecs.push_back(mk(en, 4'b0000, 4'b0000, 1'b0, eo, eb, 4'b0000));
        end

        // ch2, burst=0: done next cycle, never busy.
        cw[2] = 8'd1;
        vecs.push_back(mk(4'b0000, 4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0100));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000));

        // ch2, P=0: ena keeps it idle; start gives done next cycle.
        cp[2] = 8'd0; cb[2] = 8'd2;
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000));
        end
        vecs.push_back(mk(4'b0000, 4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0100));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000));

        // Sync at k=4 and k=12; the second lands on ch1's final wrap and extends the burst.
        cp[0] = 8'd5; cw[0] = 8'd2;
        cp[1] = 8'd4; cw[1] = 8'd1; cb[1] = 8'd2;
        cp[3] = 8'd7; cw[3] = 8'd3;
        for (int k = 0; k < 19; k++) begin
            en = '0; st = '0; eo = '0; eb = '0; ed = '0;
            en[0] = (k < 17);
            en[3] = (k >= 2) && (k < 17);
            st[1] = (k == 1);
            r = (k >= 12) ? 12 : 4;
            if (k < 17) begin
                c0 = (k >= 4) ? (k - r) % 5 : k;
                eo[0] = (c0 < 2); eb[0] = 1'b1;
            end
            if (k >= 2 && k < 17) begin
                c3 = (k >= 4) ? (k - r) % 7 : k - 2;
                eo[3] = (c3 < 3); eb[3] = 1'b1;
            end
            if (k >= 1 && k < 16) begin
                c1 = (k >= 4) ? (k - r) % 4 : k - 1;
                eo[1] = (c1 == 0); eb[1] = 1'b1;
            end
            ed[1] = (k == 16);
            vecs.push_back(mk(en, st, 4'b0010, (k == 4) || (k == 12), eo, eb, ed));
        end

        // ch0 period 5->3 while cnt=1: current period still 5 cycles, then 3.
        cp[0] = 8'd5; cw[0] = 8'd2;
        for (int k = 0; k < 13; k++) begin
            if (k == 2) cp[0] = 8'd3;
            en = '0; eo = '0; eb = '0;
            en[0] = (k < 12);
            c0 = (k < 5) ? k : (k - 5) % 3;
            eo[0] = (k < 12) && (c0 < 2);
            eb[0] = (k < 12);
            vecs.push_back(mk(en, 4'b0000, 4'b0000, 1'b0, eo, eb, 4'b0000));
        end

        // Reset state.
        bus.ena = '0; bus.start = '0; bus.mode = '0; bus.sync = 1'b0;
        bus.period = '0; bus.width = '0; bus.burst = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out", bus.out, 4'b0000);
        check("reset busy", bus.busy, 4'b0000);
        check("reset done", bus.done, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) drive(vecs[i], i);

        // Async reset mid-burst on ch1 (W>=P so out is high while running).
        cp[1] = 8'd4; cw[1] = 8'd4; cb[1] = 8'd3;
        drive(mk(4'b0000, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0000), 1000);
        drive(mk(4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0000), 1001);
        #2 rst = 1'b0;
        #1;
        check("async out", bus.out, 4'b0000);
        check("async busy", bus.busy, 4'b0000);
        check("async done", bus.done, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(mk(4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000), 1002 + k);
        end
        drive(mk(4'b0000, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0000), 1010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_pulse_generator.md
Name: multi_pulse_generator

Overview:
- C-channel programmable pulse/PWM generator; successor to the single-channel period-tick generator.
- Each channel has a runtime period, a high-time (width), and either continuous or triggered-burst mode. A global sync realigns all running channels.
- Sits beside timers/peripherals as the shared source of strobes, PWM and LED/buzzer drive.

Parameters:
- C, 4, number of independent channels
- N, 8, width of period/width/counter fields
- M, 8, width of burst-count field

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- ena  input  C  per-channel continuous-mode run enable, level
- start  input  C  per-channel burst trigger, sampled each cycle
- mode  input  C  0 = continuous, 1 = burst
- sync  input  1  global phase realign, one-cycle strobe
- period  input  C*N  channel c at [c*N +: N]; cycles per pulse period
- width  input  C*N  channel c at [c*N +: N]; high cycles per period
- burst  input  C*M  channel c at [c*M +: M]; pulses per burst
- out  output  C  pulse/PWM output
- busy  output  C  channel in RUN state
- done  output  C  one-cycle strobe at burst completion

Behaviour:
- Reset (rst=0, async): all channels IDLE, counters 0, out=0, busy=0, done=0. Release is synchronous to clk.
- Per-channel state: IDLE, RUN. Registers: cnt[N], remaining[M], latched P, W.
- Outputs while RUN: out[c] = (cnt < W). busy[c] = RUN. out is 0 in IDLE.
- Config latch:
  - P and W are sampled on the IDLE->RUN edge and at every period wrap.
  - Mid-period changes to period/width take effect at the next wrap.
- Counting in RUN: cnt increments each cycle. When cnt == P-1: cnt <= 0 (wrap). The period is exactly P cycles.
- Continuous mode (mode=0):
  - ena[c]=1 in IDLE -> RUN next cycle with cnt=0. First high cycle is that cycle if W>0.
  - ena[c]=0 in RUN -> IDLE next cycle; out drops immediately that next cycle (no period completion).
  - done is never asserted.
- Burst mode (mode=1):
  - start[c]=1 in IDLE -> RUN next cycle, cnt=0, remaining=burst.
  - remaining decrements at each wrap. The wrap with remaining==1 -> IDLE. done[c]=1 for the cycle after the last period's final cycle, i.e. the first IDLE cycle.
  - start while RUN is ignored. ena is ignored in burst mode.
- Latency: ena/start sampled at edge k; out is high in cycle k+1 (if W>0).
- Boundaries:
  - P=0: channel never enters RUN. start with P=0 gives done the next cycle; ena with P=0 keeps IDLE.
  - W=0: out stays 0 but counting/burst/done proceed normally.
  - W>=P: out constant 1 while RUN.
  - burst=0: start gives no RUN and no output; done=1 the next cycle.
  - P=2^N-1 is legal; cnt must not overflow.
- sync=1: every channel in RUN sets cnt <= 0 and relatches P/W next cycle. remaining is unchanged (no decrement) and state is unchanged. sync coincident with a wrap is treated as sync only.
- mode change while RUN is ignored until the channel returns to IDLE; mode is sampled on entry.
- Simultaneous:
  - ena[c] falling at the same edge as a wrap -> IDLE.
  - Burst last wrap together with sync -> sync wins; the burst continues one more full period from cnt=0.
- Async reset mid-burst aborts immediately; no done strobe.
- Channels are fully independent except for sync. Only the addition/compare logic of one channel's width is required; no sharing across channels.

Test Plan:
- Reset, then continuous ch0 with P=5, W=2, ena held 1 -> out[0] pattern 1,1,0,0,0 repeating from the cycle after ena; busy[0]=1; drop ena -> out=0, busy=0 next cycle.
- Burst ch1 with P=4, W=1, burst=3, start pulse at cycle 10 -> out[1] high in cycles 11, 15, 19; done[1]=1 in cycle 23 only; start at cycle 13 ignored.
- Boundaries ch2: W=0 gives out low all run; W=6 with P=4 gives out constant 1; burst=0 start -> done next cycle with busy never 1; P=0 with ena=1 -> busy stays 0.
- Sync: ch0 (P=5) and ch3 (P=7) running at arbitrary phases, sync strobe -> both cnt=0 next cycle, both out rise together; burst remaining unchanged.
- Mid-run reconfiguration: change ch0 period 5->3 at cnt=1 -> current period finishes at 5 cycles, subsequent periods are 3 cycles.
- Async reset asserted mid-burst (no clock edge) -> out/busy/done 0 immediately; after release, channel IDLE until a new start.
